// File: rtl/register_readback_serializer_if.sv
// Register-bank read port plus serial output channel of the readback serializer.
// The master side is the serializer; the slave side is the register bank and bit consumer.
interface register_readback_serializer_if #(
  parameter int NrOfBits = 32,
  parameter int AddrBits = 5
);
  logic [AddrBits-1:0] RdAddr;
  logic                RdSel;
  logic [NrOfBits-1:0] RdData;
  logic                SerOut;
  logic                SerValid;
  logic                SerReady;

  modport master (
    output RdAddr, RdSel, SerOut, SerValid,
    input  RdData, SerReady
  );

  modport slave (
    input  RdAddr, RdSel, SerOut, SerValid,
    output RdData, SerReady
  );
endinterface

// File: rtl/register_readback_serializer.sv
// Scans a bank of tri-stated registers and streams each word out MSB first over a
// valid/ready serial channel; every state update is qualified by the global Tick.
module register_readback_serializer #(
  parameter int NrOfBits = 32,
  parameter int NrOfRegs = 32,
  parameter int AddrBits = 5
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Tick,
  input  logic Start,
  register_readback_serializer_if.master bus,
  output logic Busy,
  output logic Done
);

  localparam int CntBits = (NrOfBits > 1) ? $clog2(NrOfBits) : 1;
  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NrOfRegs - 1);
  localparam logic [CntBits-1:0]  LastBit  = CntBits'(NrOfBits - 1);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    CAPTURE,
    SHIFT,
    NEXT,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [AddrBits-1:0] addr_q, addr_d;
  logic [NrOfBits-1:0] shift_q, shift_d;
  logic [CntBits-1:0]  cnt_q, cnt_d;

  // NOTE: every signal written here gets its default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    bus.RdAddr   = addr_q;
    bus.RdSel    = 1'b1;
    bus.SerOut   = shift_q[NrOfBits-1];
    bus.SerValid = 1'b0;
    Busy         = (state_q != IDLE);
    Done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = SELECT;
          addr_d  = '0;
        end
      end
      SELECT: begin
        // Register drives the bus for one settle cycle before the capture edge.
        bus.RdSel = 1'b0;
        state_d   = CAPTURE;
      end
      CAPTURE: begin
        bus.RdSel = 1'b0;
        shift_d   = bus.RdData;
        cnt_d     = LastBit;
        state_d   = SHIFT;
      end
      SHIFT: begin
        bus.SerValid = 1'b1;
        if (bus.SerReady) begin
          shift_d = shift_q << 1;
          if (cnt_q == '0) begin
            state_d = NEXT;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      NEXT: begin
        if (addr_q == LastAddr) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = SELECT;
        end
      end
      DONE: begin
        Done    = 1'b1;
        addr_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them sample the same edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (Tick) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
